// File: rtl/op_pkg.sv
// op_pkg: fetch state encoding and opcode RAM geometry shared with the loader side
package op_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;
    localparam int OP_DATA_W = 8;
    localparam int OP_ADDR_W = 4;
endpackage

// File: rtl/op_fetch_fifo.sv
// op_fifo: first-word-fall-through prefetch FIFO; an empty FIFO passes the pushed word straight to the head
module op_fifo import op_pkg::*; #(
    parameter int W     = OP_DATA_W + OP_ADDR_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty, wr_en, rd_en;
    assign empty = cnt_q == '0;
    assign valid = !empty || push;
    assign dout  = !empty ? mem_q[rd_q] : push ? din : '0;
    assign rd_en = pop && !empty;
    assign wr_en = push && !(empty && pop);
    assign count = cnt_q;
    always_comb begin
        wr_d  = flush ? '0 : wr_q + PW'(wr_en);
        rd_d  = flush ? '0 : rd_q + PW'(rd_en);
        cnt_d = flush ? '0 : cnt_q + CW'(wr_en) - CW'(rd_en);
    end
    always_ff @(posedge clk)
        if (wr_en) mem_q[wr_q] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk)
        if (!rst) assert (!(push && !pop && !flush && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/op_fetch.sv
// op_fetch: opcode RAM reader with read-latency tracking, prefetch FIFO, jump flush and loader hold
module op_fetch import op_pkg::*; #(
    parameter int ADDR_W     = OP_ADDR_W,
    parameter int DATA_W     = OP_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              load_busy,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic [ADDR_W-1:0] ram_ad,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] op,
    output logic [ADDR_W-1:0] op_pc,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              running
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LAT) + 1;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ad_q, ad_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [ADDR_W-1:0] pa_q [RD_LAT];
    logic [ADDR_W-1:0] pa_d [RD_LAT];
    logic [FCW-1:0]    fifo_cnt;
    logic [CW-1:0]     inflight;
    logic              flush, push, pop;
    assign pop = op_valid && op_ready;
    always_comb begin
        flush    = jump && state_q != IDLE;
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pv_q[i]);
        // credit: never have more reads outstanding than the FIFO can absorb
        ram_ce   = state_q == RUN && !load_busy && !flush
                   && CW'(fifo_cnt) + inflight < CW'(FIFO_DEPTH);
        ram_oce  = !load_busy;
        ram_ad   = ram_ce ? pc_q : ad_q;
        running  = state_q != IDLE;
        push     = pv_q[RD_LAT-1] && !flush;
        pv_d[0]  = ram_ce;
        pa_d[0]  = pc_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1] && !flush;
            pa_d[i] = pa_q[i-1];
        end
        state_d  = (state_q == IDLE && start)     ? RUN  :
                   (state_q == RUN  && load_busy)  ? HOLD :
                   (state_q == HOLD && !load_busy) ? RUN  : state_q;
        pc_d     = (state_q == IDLE && start) ? start_addr :
                   flush                      ? jump_addr  :
                   ram_ce                     ? pc_q + 1'b1 : pc_q;
        ad_d     = ram_ce ? pc_q : ad_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ad_q    <= '0;
            pv_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ad_q    <= ad_d;
            pv_q    <= pv_d;
        end
    end
    always_ff @(posedge clk) pa_q <= pa_d;
    op_fifo #(.W(DATA_W + ADDR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({ram_dout, pa_q[RD_LAT-1]}),
        .dout  ({op, op_pc}),
        .valid (op_valid),
        .count (fifo_cnt)
    );
endmodule

// File: tb/tb_op_fetch.sv
// tb_op_fetch: directed plan plus random traffic against a program-order scoreboard
module tb_op_fetch;
    localparam int AW = 4;
    localparam int DW = 8;
    logic          clk = 0, rst = 1, start = 0, jump = 0, load_busy = 0, op_ready = 0;
    logic [AW-1:0] start_addr = '0, jump_addr = '0;
    logic          ram_ce, ram_oce, op_valid, running;
    logic [AW-1:0] ram_ad, op_pc;
    logic [DW-1:0] ram_dout, op;
    logic [DW-1:0] mem [16];
    int            errors = 0, checks = 0;
    typedef struct packed { logic [AW-1:0] pc; logic [DW-1:0] op; } exp_t;
    exp_t          sb[$];
    bit            model_run = 0;

    always #5 clk = ~clk;

    op_fetch dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .jump(jump), .jump_addr(jump_addr), .load_busy(load_busy),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_ad(ram_ad), .ram_dout(ram_dout),
        .op(op), .op_pc(op_pc), .op_valid(op_valid), .op_ready(op_ready),
        .running(running)
    );

    always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_ad];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // program order from a given address: every delivered op is mem[pc] with pc counting up mod 16
    function automatic void fill(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        sb.delete();
        for (int i = 0; i < 512; i++) begin
            p = a + AW'(i);
            sb.push_back('{pc: p, op: mem[p]});
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_run = 0;
            sb.delete();
        end else if (!model_run && start) begin
            model_run = 1;
            fill(start_addr);
        end else if (model_run && jump) begin
            fill(jump_addr);
        end
    end

    logic          pv = 0, pr = 0, pj = 0, prun = 0;
    logic [DW-1:0] p_op;
    logic [AW-1:0] p_pc;
    int            stall = 0;
    exp_t          e;
    always @(negedge clk) begin
        if (rst) begin
            pv = 0; pj = 0; stall = 0;
        end else begin
            chk("oce", ram_oce, !load_busy);
            chk("running", running, model_run);
            if (load_busy || !model_run) chk("ce_blocked", ram_ce, 0);
            if (!model_run) chk("idle_valid", op_valid, 0);
            if (pv && !pr && !pj) begin
                chk("hold_valid", op_valid, 1);
                chk("hold_op", op, p_op);
                chk("hold_pc", op_pc, p_pc);
            end
            if (pj && prun) chk("post_jump_valid", op_valid, 0);
            if (op_valid && op_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got op %0h pc %0h, expected no transfer", op, op_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", op_pc, e.pc);
                    chk("sb_op", op, e.op);
                end
            end
            stall = (model_run && !load_busy && op_ready && !op_valid) ? stall + 1 : 0;
            if (stall > 8) begin
                checks++; errors++;
                $display("FAIL stall_timeout: got no op_valid for %0d cycles, expected delivery", stall);
                stall = 0;
            end
            pv = op_valid; pr = op_ready; pj = jump; prun = model_run; p_op = op; p_pc = op_pc;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!op_valid && n < 8) begin
            cyc(1); #2; n++;
        end
        chk(name, op_valid, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        cyc(3);
        rst = 0; #2;
        chk("rst_valid", op_valid, 0);
        chk("rst_op", op, 0);
        chk("rst_pc", op_pc, 0);
        chk("rst_ce", ram_ce, 0);
        chk("rst_ad", ram_ad, 0);
        chk("rst_running", running, 0);
        cyc(1); start = 1; start_addr = 0; op_ready = 1;
        cyc(1); start = 0; #2;
        chk("lat_ce", ram_ce, 1);
        chk("lat_ad", ram_ad, 0);
        chk("lat_novalid", op_valid, 0);
        cyc(1); #2;
        chk("lat_valid", op_valid, 1);
        chk("first_op", op, 8'h10);
        chk("first_pc", op_pc, 0);
        cyc(6);
        op_ready = 0;
        cyc(4); #2;
        chk("stall_ce", ram_ce, 0);
        cyc(1); op_ready = 1;
        cyc(22);
        op_ready = 0;
        cyc(3); jump = 1; jump_addr = 9;
        cyc(1); jump = 0; op_ready = 1; #2;
        chk("jump_flush", op_valid, 0);
        chk("jump_ce", ram_ce, 1);
        chk("jump_ad", ram_ad, 9);
        wait_valid("jump_timeout");
        chk("jump_op", op, 8'h19);
        chk("jump_pc", op_pc, 9);
        cyc(4); op_ready = 0;
        cyc(2); op_ready = 1; load_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("busy_ce", ram_ce, 0);
            chk("busy_oce", ram_oce, 0);
            cyc(1);
        end
        load_busy = 0;
        cyc(8);
        load_busy = 1;
        cyc(2); jump = 1; jump_addr = 5;
        cyc(1); jump = 0;
        cyc(2); load_busy = 0; #2;
        wait_valid("busy_jump_timeout");
        chk("busy_jump_op", op, 8'h15);
        chk("busy_jump_pc", op_pc, 5);
        cyc(3); op_ready = 0;
        cyc(3); rst = 1;
        cyc(1); rst = 0; #2;
        chk("rst2_valid", op_valid, 0);
        chk("rst2_ce", ram_ce, 0);
        chk("rst2_running", running, 0);
        cyc(1); start = 1; start_addr = 3; op_ready = 1;
        cyc(1); start = 0; #2;
        wait_valid("restart_timeout");
        chk("restart_op", op, 8'h13);
        chk("restart_pc", op_pc, 3);
        for (int i = 0; i < 800; i++) begin
            cyc(1);
            op_ready   = $urandom_range(0, 3) != 0;
            start      = $urandom_range(0, 7) == 0;
            start_addr = AW'($urandom);
            jump       = $urandom_range(0, 15) == 0;
            jump_addr  = AW'($urandom);
            rst        = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 9) == 0) load_busy = !load_busy;
        end
        cyc(1);
        rst = 0; start = 0; jump = 0; load_busy = 0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
